// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128 key schedule.
// Loads a 128-bit cipher key and produces one round key per cycle into an
// internal buffer. The round datapath reads the buffer by index through a
// registered read port. SubWord uses an external combinational S-box, reached
// through the sub_in / sub_out side port.
// Optional feature macro: AES_KEYEXP_LASTKEY_EN adds a registered last_key
// output that holds round key NR while the keys are valid.

module aes_key_expander #(
    parameter int NR = 10
) (
    input  logic         HCLK,
    input  logic         HRESET,
    input  logic         start,
    input  logic [127:0] keyWord,
    output logic [31:0]  sub_in,
    input  logic [31:0]  sub_out,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_rd_data,
    output logic         busy,
    output logic         keys_valid
`ifdef AES_KEYEXP_LASTKEY_EN
    ,
    output logic [127:0] last_key
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_RND = 4'(NR);

    // Control and working state
    state_t       r_state;
    logic [31:0]  r_w [0:3];
    logic [3:0]   r_rnd;
    logic [7:0]   r_rcon;
    logic         r_busy;
    logic         r_keys_valid;
    logic [127:0] r_rd_data;

    // Round-key buffer, written one entry per cycle, read through a register
    logic [127:0] r_rk [0:NR];

    // Combinational next-round values
    logic         w_expand;
    logic         w_accept;
    logic         w_last;
    logic [31:0]  w_t;
    logic [31:0]  w_n [0:3];
    logic [127:0] w_next_key;
    logic [7:0]   w_rcon_next;
    logic         w_wr_en;
    logic [3:0]   w_wr_addr;
    logic [127:0] w_wr_data;

    assign w_expand = (r_state == ST_EXPAND);
    // A start while already expanding is deliberately dropped
    assign w_accept = start && !w_expand;
    assign w_last   = w_expand && (r_rnd == LAST_RND);

    // RotWord of w3 goes out to the S-box only while expanding
    assign sub_in = w_expand ? {r_w[3][23:0], r_w[3][31:24]} : 32'h0;

    assign w_t = sub_out ^ {r_rcon, 24'h0};

    // Word chain: each new word folds in the previous new word
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chain
            if (gi == 0) begin : g_first
                assign w_n[gi] = r_w[gi] ^ w_t;
            end else begin : g_rest
                assign w_n[gi] = r_w[gi] ^ w_n[gi-1];
            end
        end
    endgenerate

    assign w_next_key = {w_n[0], w_n[1], w_n[2], w_n[3]};

    // xtime in GF(2^8)
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    // Single buffer write port: key at load, new round key while expanding
    assign w_wr_en   = !HRESET && (w_accept || w_expand);
    assign w_wr_addr = w_accept ? 4'd0 : r_rnd;
    assign w_wr_data = w_accept ? keyWord : w_next_key;

    // Sequencer: load, step through rounds 1..NR, then hold
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b0;
            r_rnd        <= 4'd0;
            r_rcon       <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                r_w[i] <= 32'h0;
            end
        end else if (w_accept) begin
            r_state      <= ST_EXPAND;
            r_busy       <= 1'b1;
            r_keys_valid <= 1'b0;
            r_rnd        <= 4'd1;
            r_rcon       <= 8'h01;
            r_w[0]       <= keyWord[127:96];
            r_w[1]       <= keyWord[95:64];
            r_w[2]       <= keyWord[63:32];
            r_w[3]       <= keyWord[31:0];
        end else if (w_expand) begin
            r_rcon <= w_rcon_next;
            for (int i = 0; i < 4; i++) begin
                r_w[i] <= w_n[i];
            end
            if (w_last) begin
                r_state      <= ST_DONE;
                r_busy       <= 1'b0;
                r_keys_valid <= 1'b1;
            end else begin
                r_rnd <= r_rnd + 4'd1;
            end
        end
    end

    // Buffer write; contents need no reset since reads are gated by keys_valid
    always_ff @(posedge HCLK) begin
        if (w_wr_en) begin
            r_rk[w_wr_addr] <= w_wr_data;
        end
    end

    // Registered read, zero unless keys are valid and the index is in range
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_rd_data <= 128'h0;
        end else if (r_keys_valid && (rk_rd_idx <= LAST_RND)) begin
            r_rd_data <= r_rk[rk_rd_idx];
        end else begin
            r_rd_data <= 128'h0;
        end
    end

    assign rk_rd_data = r_rd_data;
    assign busy       = r_busy;
    assign keys_valid = r_keys_valid;

`ifdef AES_KEYEXP_LASTKEY_EN
    logic [127:0] r_last_key;

    // Final round key captured as it is produced, cleared on any (re)load
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_last_key <= 128'h0;
        end else if (w_accept) begin
            r_last_key <= 128'h0;
        end else if (w_last) begin
            r_last_key <= w_next_key;
        end
    end

    assign last_key = r_last_key;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key vectors and a
// behavioural S-box built from GF(2^8) inversion plus the affine map.

`timescale 1ns/1ps

module tb_aes_key_expander;

    logic         HCLK;
    logic         HRESET;
    logic         start;
    logic [127:0] keyWord;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic         busy;
    logic         keys_valid;
`ifdef AES_KEYEXP_LASTKEY_EN
    logic [127:0] last_key;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] sbox [256];
    logic [7:0] rcon_seen [10];

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A_R2 = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] KEY_A_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KEY_B_RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_expander #(.NR(10)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .start      (start),
        .keyWord    (keyWord),
        .sub_in     (sub_in),
        .sub_out    (sub_out),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data),
        .busy       (busy),
        .keys_valid (keys_valid)
`ifdef AES_KEYEXP_LASTKEY_EN
        ,
        .last_key   (last_key)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    assign sub_out = {sbox[sub_in[31:24]], sbox[sub_in[23:16]],
                      sbox[sub_in[15:8]],  sbox[sub_in[7:0]]};

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %032h expected %032h", tag, got, exp);
        end else begin
            $display("ok   %s: %032h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Pulse start for one edge (E0)
    task automatic do_start(input logic [127:0] key);
        keyWord = key;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Count edges after E0 until keys_valid, bounded; records rcon per cycle
    task automatic wait_kv(output int n);
        n = 0;
        while (!keys_valid && n < 20) begin
            if (n < 10) rcon_seen[n] = dut.r_rcon;
            tick();
            n++;
        end
    endtask

    task automatic read_key(input logic [3:0] idx, output logic [127:0] data);
        rk_rd_idx = idx;
        tick();
        data = rk_rd_data;
    endtask

    initial begin
        int n;
        logic [127:0] d;
        logic [7:0] rcon_exp [10];
        rcon_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

        build_sbox();
        HRESET    = 1'b1;
        start     = 1'b0;
        keyWord   = 128'h0;
        rk_rd_idx = 4'd0;
        tick();
        tick();
        HRESET = 1'b0;
        tick();

        // Reset state
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_kv", 128'(keys_valid), 128'd0);
        check("rst_rd", rk_rd_data, 128'h0);
        check("idle_sub_in", 128'(sub_in), 128'h0);
`ifdef AES_KEYEXP_LASTKEY_EN
        check("rst_last_key", last_key, 128'h0);
`endif

        // First expansion with the FIPS-197 key
        do_start(KEY_A);
        check("e0_busy", 128'(busy), 128'd1);
        check("e0_kv", 128'(keys_valid), 128'd0);
        check("e0_sub_in", 128'(sub_in), 128'hcf4f3c09);
        tick();
        tick();
        check("expand_rd_zero", rk_rd_data, 128'h0);
        // Rewind the count: two edges already consumed since E0
        n = 0;
        while (!keys_valid && n < 20) begin
            tick();
            n++;
        end
        check("kv_latency", 128'(n + 2), 128'd10);
        check("done_busy", 128'(busy), 128'd0);
        check("done_sub_in", 128'(sub_in), 128'h0);
`ifdef AES_KEYEXP_LASTKEY_EN
        check("last_key_a", last_key, KEY_A_RA);
`endif
        read_key(4'd0, d);  check("a_rk0", d, KEY_A);
        read_key(4'd1, d);  check("a_rk1", d, KEY_A_R1);
        read_key(4'd2, d);  check("a_rk2", d, KEY_A_R2);
        read_key(4'd10, d); check("a_rk10", d, KEY_A_RA);
        read_key(4'd11, d); check("a_idx11_zero", d, 128'h0);
        read_key(4'd15, d); check("a_idx15_zero", d, 128'h0);

        // Reset then a clean run, monitoring rcon
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        do_start(KEY_A);
        wait_kv(n);
        check("rcon_run_latency", 128'(n), 128'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("rcon_%0d", i), 128'(rcon_seen[i]), 128'(rcon_exp[i]));
        end

        // Start re-pulsed at E5 with another key must be ignored
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        do_start(KEY_A);
        for (int i = 0; i < 4; i++) tick();
        do_start(KEY_B);
        n = 0;
        while (!keys_valid && n < 20) begin
            tick();
            n++;
        end
        check("ignore_latency", 128'(n + 5), 128'd10);
        read_key(4'd1, d);  check("ignore_rk1", d, KEY_A_R1);
        read_key(4'd10, d); check("ignore_rk10", d, KEY_A_RA);

        // Restart from DONE with the second key
        do_start(KEY_B);
        check("restart_kv_drop", 128'(keys_valid), 128'd0);
        check("restart_busy", 128'(busy), 128'd1);
`ifdef AES_KEYEXP_LASTKEY_EN
        check("restart_last_key", last_key, 128'h0);
`endif
        wait_kv(n);
        check("b_latency", 128'(n), 128'd10);
        read_key(4'd0, d);  check("b_rk0", d, KEY_B);
        read_key(4'd1, d);  check("b_rk1", d, KEY_B_R1);
        read_key(4'd10, d); check("b_rk10", d, KEY_B_RA);

        // Reset at E4 of an expansion
        do_start(KEY_B);
        for (int i = 0; i < 3; i++) tick();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_kv", 128'(keys_valid), 128'd0);
        check("midrst_rd", rk_rd_data, 128'h0);
        check("midrst_sub_in", 128'(sub_in), 128'h0);
        check("midrst_rnd", 128'(dut.r_rnd), 128'd0);
        check("midrst_rcon", 128'(dut.r_rcon), 128'd0);
`ifdef AES_KEYEXP_LASTKEY_EN
        check("midrst_last_key", last_key, 128'h0);
`endif
        tick();
        do_start(KEY_A);
        wait_kv(n);
        check("post_rst_latency", 128'(n), 128'd10);
        read_key(4'd10, d); check("post_rst_rk10", d, KEY_A_RA);
        read_key(4'd1, d);  check("post_rst_rk1", d, KEY_A_R1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Exclusivity of busy and keys_valid, checked on every falling edge
    always @(negedge HCLK) begin
        if (busy && keys_valid) begin
            check("busy_kv_exclusive", 128'd1, 128'd0);
        end
    end

endmodule
